stage_writeback_pipe: RTL and testbench

- Parametrised next-generation writeback stage of the in-order RISC-V pipeline; sits between the memory stage and the register file and forwarding network.
- Registers the result mux like the previous writeback stage, and adds:
  - valid/stall/flush pipeline control
  - load byte/half/word(/double) alignment with sign/zero extension
  - x0 write suppression and a misaligned-load flag
  - XLEN and register-address-width generalisation

---
 rtl/wb_pkg.sv | 40 ++++
 rtl/stage_writeback_pipe_load_align.sv | 51 +++++
 rtl/stage_writeback_pipe.sv | 123 ++++++++++++
 tb/tb_stage_writeback_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   result_src_e   : encoding of the write-data source selected at writeback
//   F3_*           : funct3 encodings of the RISC-V load instructions
//   access_bytes() : access size in bytes of a load funct3 (0 = not a load
//                    this datapath width supports)
package wb_pkg;

   typedef enum logic [1:0] {
      RES_ALU       = 2'b00,
      RES_MEM       = 2'b01,
      RES_PC_PLUS   = 2'b10,
      RES_LUI_AUIPC = 2'b11
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // LWU and LD only exist on RV64; on RV32 they report size 0 so the
   // raw word passes through and no misalignment is ever flagged.
   function automatic logic [3:0] access_bytes(input logic [2:0] funct3,
                                               input logic       rv64);
      logic [3:0] size;
      size = 4'd0;
      case (funct3)
         F3_LB, F3_LBU: size = 4'd1;
         F3_LH, F3_LHU: size = 4'd2;
         F3_LW:         size = 4'd4;
         F3_LWU:        size = rv64 ? 4'd4 : 4'd0;
         F3_LD:         size = rv64 ? 4'd8 : 4'd0;
         default:       size = 4'd0;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/stage_writeback_pipe_load_align.sv
// load_align: combinational load extraction and sign/zero extension.
// Ports:
//   funct3     in  3       load size/sign encoding
//   offset     in  OFF_W   byte offset of the access within the word
//   raw        in  XLEN    raw memory word
//   data       out XLEN    extracted and extended load value
//   misaligned out 1       offset is not a multiple of the access size
module load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int OFF_W = $clog2(XLEN / 8)
) (
   input  logic [2:0]       funct3,
   input  logic [OFF_W-1:0] offset,
   input  logic [XLEN-1:0]  raw,
   output logic [XLEN-1:0]  data,
   output logic             misaligned
);

   logic [XLEN-1:0]  shifted;
   logic [3:0]       size;
   logic [OFF_W-1:0] size_mask;

   // Bring the addressed byte down to bit 0, then pick and extend the field.
   // Unsupported encodings fall through with the raw word.
   always_comb begin
      shifted = raw >> {offset, 3'b000};
      data    = raw;
      case (funct3)
         F3_LB:  data = XLEN'($signed(shifted[7:0]));
         F3_LBU: data = XLEN'(shifted[7:0]);
         F3_LH:  data = XLEN'($signed(shifted[15:0]));
         F3_LHU: data = XLEN'(shifted[15:0]);
         F3_LW:  data = XLEN'($signed(shifted[31:0]));
         F3_LWU: if (XLEN == 64) data = XLEN'(shifted[31:0]);
         F3_LD:  if (XLEN == 64) data = shifted;
         default: data = raw;
      endcase
   end

   // Access sizes are powers of two, so size-1 truncated to the offset width
   // is the mask of offset bits that must be zero (a full-word access wraps
   // to an all-ones mask, which is exactly right).
   always_comb begin
      size       = access_bytes(funct3, XLEN == 64);
      size_mask  = OFF_W'(size - 4'd1);
      misaligned = (size != 4'd0) && ((offset & size_mask) != '0);
   end

endmodule

// File: rtl/stage_writeback_pipe.sv
// stage_writeback_pipe: registered writeback stage between the memory stage
// and the register file / forwarding network, with valid/stall/flush control,
// load alignment and extension, x0 write suppression and a misaligned-load flag.
// Optional feature macro: WB_RETIRE_CNT_EN adds the 64-bit wb_instret counter.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_valid / mem_ready      memory-stage handshake (mem_ready = !wb_stall)
//   wb_stall, wb_flush         hold / kill control
//   mem_rd, mem_result_src, mem_funct3, mem_alu_result, mem_read_data,
//   mem_instr_addr_plus, mem_regfile_wr_enable   incoming instruction fields
//   wb_valid, wb_rd, wb_write_data, wb_regfile_wr_enable, wb_load_misaligned
//                              registered writeback outputs
//   wb_instret (WB_RETIRE_CNT_EN only)  retired instruction count
module stage_writeback_pipe
   import wb_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int RA_W       = 5,
   parameter int LOAD_ALIGN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic            wb_stall,
   input  logic            wb_flush,
   input  logic [RA_W-1:0] mem_rd,
   input  logic [1:0]      mem_result_src,
   input  logic [2:0]      mem_funct3,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_read_data,
   input  logic [XLEN-1:0] mem_instr_addr_plus,
   input  logic            mem_regfile_wr_enable,
   output logic            wb_valid,
   output logic [RA_W-1:0] wb_rd,
   output logic [XLEN-1:0] wb_write_data,
   output logic            wb_regfile_wr_enable,
   output logic            wb_load_misaligned
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [63:0]     wb_instret
`endif
);

   localparam int OFF_W = $clog2(XLEN / 8);

   result_src_e     src;
   logic [XLEN-1:0] aligned_data;
   logic            align_misaligned;
   logic [XLEN-1:0] load_value;
   logic [XLEN-1:0] result;
   logic            is_misaligned;
   logic            next_wr_enable;

   assign mem_ready = !wb_stall;
   assign src       = result_src_e'(mem_result_src);

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3     (mem_funct3),
      .offset     (mem_alu_result[OFF_W-1:0]),
      .raw        (mem_read_data),
      .data       (aligned_data),
      .misaligned (align_misaligned)
   );

   // With LOAD_ALIGN=0 the memory stage has already aligned the data, but the
   // misalignment check still applies since it depends only on address/size.
   assign load_value = (LOAD_ALIGN != 0) ? aligned_data : mem_read_data;

   always_comb begin
      result = mem_alu_result;
      case (src)
         RES_MEM:     result = load_value;
         RES_PC_PLUS: result = mem_instr_addr_plus;
         default:     result = mem_alu_result;
      endcase
   end

   // A misaligned load is still retired into the slot (so the flag travels
   // with it) but must never write the register file; x0 is never written.
   assign is_misaligned  = (src == RES_MEM) && align_misaligned;
   assign next_wr_enable = mem_regfile_wr_enable && (mem_rd != '0) && !is_misaligned;

   // Flush outranks stall; a stall holds everything, including an asserted
   // strobe, since rewriting the same register with the same value is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid             <= 1'b0;
         wb_rd                <= '0;
         wb_write_data        <= '0;
         wb_regfile_wr_enable <= 1'b0;
         wb_load_misaligned   <= 1'b0;
      end else if (wb_flush) begin
         wb_valid             <= 1'b0;
         wb_regfile_wr_enable <= 1'b0;
         wb_load_misaligned   <= 1'b0;
      end else if (!wb_stall) begin
         if (mem_valid) begin
            wb_valid             <= 1'b1;
            wb_rd                <= mem_rd;
            wb_write_data        <= result;
            wb_regfile_wr_enable <= next_wr_enable;
            wb_load_misaligned   <= is_misaligned;
         end else begin
            wb_valid             <= 1'b0;
            wb_regfile_wr_enable <= 1'b0;
            wb_load_misaligned   <= 1'b0;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // Counts instructions actually accepted into writeback; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_instret <= '0;
      end else if (mem_valid && !wb_stall && !wb_flush && !is_misaligned) begin
         wb_instret <= wb_instret + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stage_writeback_pipe.sv
// Self-checking bench for stage_writeback_pipe. Two instances share stimulus:
// one with XLEN=32 and one with XLEN=64. Expected values come from a
// behavioural model of the stage written with plain arithmetic.
// WB_RETIRE_CNT_EN, when defined, also enables the wb_instret checks.
module tb_stage_writeback_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_stall, s_flush, s_we;
   logic [4:0]  s_rd;
   logic [1:0]  s_src;
   logic [2:0]  s_f3;
   logic [63:0] s_alu, s_rdata, s_pc;

   logic        ready32, valid32, we32, mis32;
   logic [4:0]  rd32;
   logic [31:0] data32;
   logic        ready64, valid64, we64, mis64;
   logic [4:0]  rd64;
   logic [63:0] data64;
   logic [63:0] cnt32, cnt64;

   logic        exp_valid [2];
   logic        exp_we    [2];
   logic        exp_mis   [2];
   logic [4:0]  exp_rd    [2];
   logic [63:0] exp_data  [2];
   logic [63:0] exp_cnt   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stage_writeback_pipe #(.XLEN(32), .RA_W(5), .LOAD_ALIGN(1)) dut32 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .mem_valid             (s_valid),
      .mem_ready             (ready32),
      .wb_stall              (s_stall),
      .wb_flush              (s_flush),
      .mem_rd                (s_rd),
      .mem_result_src        (s_src),
      .mem_funct3            (s_f3),
      .mem_alu_result        (s_alu[31:0]),
      .mem_read_data         (s_rdata[31:0]),
      .mem_instr_addr_plus   (s_pc[31:0]),
      .mem_regfile_wr_enable (s_we),
      .wb_valid              (valid32),
      .wb_rd                 (rd32),
      .wb_write_data         (data32),
      .wb_regfile_wr_enable  (we32),
      .wb_load_misaligned    (mis32)
`ifdef WB_RETIRE_CNT_EN
      ,
      .wb_instret            (cnt32)
`endif
   );

   stage_writeback_pipe #(.XLEN(64), .RA_W(5), .LOAD_ALIGN(1)) dut64 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .mem_valid             (s_valid),
      .mem_ready             (ready64),
      .wb_stall              (s_stall),
      .wb_flush              (s_flush),
      .mem_rd                (s_rd),
      .mem_result_src        (s_src),
      .mem_funct3            (s_f3),
      .mem_alu_result        (s_alu),
      .mem_read_data         (s_rdata),
      .mem_instr_addr_plus   (s_pc),
      .mem_regfile_wr_enable (s_we),
      .wb_valid              (valid64),
      .wb_rd                 (rd64),
      .wb_write_data         (data64),
      .wb_regfile_wr_enable  (we64),
      .wb_load_misaligned    (mis64)
`ifdef WB_RETIRE_CNT_EN
      ,
      .wb_instret            (cnt64)
`endif
   );

`ifndef WB_RETIRE_CNT_EN
   assign cnt32 = 64'd0;
   assign cnt64 = 64'd0;
`endif

   // Single comparison point: counts the check and reports any failure.
   task automatic check_output(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference load semantics: select the addressed field by byte arithmetic,
   // then extend; unsupported encodings return the raw word.
   task automatic model_load(input int xl, input logic [2:0] f3,
                             input logic [63:0] alu, input logic [63:0] raw_in,
                             output logic [63:0] val, output bit mis);
      logic [63:0] raw, field, mask;
      int nbytes, off, size;
      bit sgn;
      raw    = (xl == 32) ? (raw_in & 64'hFFFF_FFFF) : raw_in;
      nbytes = xl / 8;
      off    = int'(alu % 64'(nbytes));
      size   = 0;
      sgn    = 0;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd4: begin size = 1; sgn = 0; end
         3'd1: begin size = 2; sgn = 1; end
         3'd5: begin size = 2; sgn = 0; end
         3'd2: begin size = 4; sgn = 1; end
         3'd6: begin size = (xl == 64) ? 4 : 0; sgn = 0; end
         3'd3: begin size = (xl == 64) ? 8 : 0; sgn = 0; end
         default: size = 0;
      endcase
      if (size == 0) begin
         val = raw;
         mis = 0;
      end else begin
         mis   = (off % size) != 0;
         mask  = (size == 8) ? {64{1'b1}} : ((64'd1 << (8 * size)) - 64'd1);
         field = (raw >> (8 * off)) & mask;
         if (sgn && field[8*size-1]) field = field | ~mask;
         val = (xl == 32) ? (field & 64'hFFFF_FFFF) : field;
      end
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_edge();
      logic [63:0] lv, res;
      bit lm, mis;
      int xl;
      for (int i = 0; i < 2; i++) begin
         xl = (i == 0) ? 32 : 64;
         if (s_flush) begin
            exp_valid[i] = 0; exp_we[i] = 0; exp_mis[i] = 0;
         end else if (s_stall) begin
            // everything holds
         end else if (s_valid) begin
            model_load(xl, s_f3, s_alu, s_rdata, lv, lm);
            case (s_src)
               2'd1:    res = lv;
               2'd2:    res = s_pc;
               default: res = s_alu;
            endcase
            if (xl == 32) res = res & 64'hFFFF_FFFF;
            mis          = (s_src == 2'd1) && lm;
            exp_valid[i] = 1;
            exp_rd[i]    = s_rd;
            exp_data[i]  = res;
            exp_mis[i]   = mis;
            exp_we[i]    = s_we && (s_rd != 5'd0) && !mis;
            if (!mis) exp_cnt[i] = exp_cnt[i] + 64'd1;
         end else begin
            exp_valid[i] = 0; exp_we[i] = 0; exp_mis[i] = 0;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         exp_valid[i] = 0; exp_we[i] = 0; exp_mis[i] = 0;
         exp_rd[i] = 5'd0; exp_data[i] = 64'd0; exp_cnt[i] = 64'd0;
      end
   endtask

   task automatic check_state(input string tag);
      check_output({tag, "/x32 valid"}, 64'(valid32), 64'(exp_valid[0]));
      check_output({tag, "/x32 we"},    64'(we32),    64'(exp_we[0]));
      check_output({tag, "/x32 mis"},   64'(mis32),   64'(exp_mis[0]));
      check_output({tag, "/x64 valid"}, 64'(valid64), 64'(exp_valid[1]));
      check_output({tag, "/x64 we"},    64'(we64),    64'(exp_we[1]));
      check_output({tag, "/x64 mis"},   64'(mis64),   64'(exp_mis[1]));
      if (exp_valid[0]) check_output({tag, "/x32 rd"}, 64'(rd32), 64'(exp_rd[0]));
      if (exp_valid[1]) check_output({tag, "/x64 rd"}, 64'(rd64), 64'(exp_rd[1]));
      if (exp_valid[0] && !exp_mis[0]) check_output({tag, "/x32 data"}, 64'(data32), exp_data[0]);
      if (exp_valid[1] && !exp_mis[1]) check_output({tag, "/x64 data"}, data64, exp_data[1]);
`ifdef WB_RETIRE_CNT_EN
      check_output({tag, "/x32 instret"}, cnt32, exp_cnt[0]);
      check_output({tag, "/x64 instret"}, cnt64, exp_cnt[1]);
`endif
   endtask

   // Drive one memory-stage slot just after a falling edge, check mem_ready,
   // clock it through and check the writeback outputs at the next falling edge.
   task automatic apply_stimulus(input string tag, input bit v, input bit st,
                                 input bit fl, input logic [4:0] rd,
                                 input logic [1:0] src, input logic [2:0] f3,
                                 input logic [63:0] alu, input logic [63:0] rdata,
                                 input logic [63:0] pc, input bit we);
      s_valid = v; s_stall = st; s_flush = fl; s_rd = rd; s_src = src;
      s_f3 = f3; s_alu = alu; s_rdata = rdata; s_pc = pc; s_we = we;
      #1;
      check_output({tag, "/x32 ready"}, 64'(ready32), 64'(!st));
      check_output({tag, "/x64 ready"}, 64'(ready64), 64'(!st));
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_state(tag);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_output({tag, "/x32 valid"}, 64'(valid32), 64'd0);
      check_output({tag, "/x32 data"},  64'(data32),  64'd0);
      check_output({tag, "/x32 rd"},    64'(rd32),    64'd0);
      check_output({tag, "/x64 we"},    64'(we64),    64'd0);
      check_output({tag, "/x64 data"},  data64,       64'd0);
      check_state(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] base32, base64;
      rst_n = 1'b0;
      s_valid = 0; s_stall = 0; s_flush = 0; s_we = 0; s_rd = '0; s_src = '0;
      s_f3 = '0; s_alu = '0; s_rdata = '0; s_pc = '0;
      model_reset();
      #1;
      check_state("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      apply_stimulus("alu0", 1, 0, 0, 5'd9, 2'b00, 3'd0, 64'hDEAD_BEEF, 64'd0, 64'd0, 1);
      async_reset("midreset");
      apply_stimulus("alu", 1, 0, 0, 5'd5, 2'b00, 3'd0, 64'h1234_5678, 64'd0, 64'd0, 1);
      check_output("alu/const", 64'(data32), 64'h1234_5678);

      apply_stimulus("lb", 1, 0, 0, 5'd3, 2'b01, 3'b000, 64'h2, 64'h80FF_7F01, 64'd0, 1);
      check_output("lb/const", 64'(data32), 64'hFFFF_FFFF);
      apply_stimulus("lbu", 1, 0, 0, 5'd3, 2'b01, 3'b100, 64'h1, 64'h80FF_7F01, 64'd0, 1);
      check_output("lbu/const", 64'(data32), 64'h7F);
      apply_stimulus("lh", 1, 0, 0, 5'd3, 2'b01, 3'b001, 64'h2, 64'h80FF_7F01, 64'd0, 1);
      check_output("lh/const", 64'(data32), 64'hFFFF_80FF);
      apply_stimulus("lwmis", 1, 0, 0, 5'd4, 2'b01, 3'b010, 64'h1001, 64'h1111_2222, 64'd0, 1);
      check_output("lwmis/const", 64'(mis32), 64'd1);

      apply_stimulus("hold0", 1, 0, 0, 5'd7, 2'b00, 3'd0, 64'hA5A5_A5A5, 64'd0, 64'd0, 1);
      for (int k = 0; k < 3; k++)
         apply_stimulus("stall", 1, 1, 0, 5'(k + 10), 2'b10, 3'd2, 64'(k), 64'd0, 64'h44, 1);
      check_output("stall/const", 64'(data32), 64'hA5A5_A5A5);
      apply_stimulus("stallflush", 1, 1, 1, 5'd8, 2'b00, 3'd0, 64'h55, 64'd0, 64'd0, 1);

      apply_stimulus("x0", 1, 0, 0, 5'd0, 2'b00, 3'd0, 64'h99, 64'd0, 64'd0, 1);
      apply_stimulus("jal", 1, 0, 0, 5'd1, 2'b10, 3'd0, 64'h7, 64'd0, 64'h104, 1);
      check_output("jal/const", 64'(data32), 64'h104);
      apply_stimulus("idle", 0, 0, 0, 5'd2, 2'b00, 3'd0, 64'h1, 64'd0, 64'd0, 1);

      apply_stimulus("lwu", 1, 0, 0, 5'd6, 2'b01, 3'b110, 64'h0, 64'hFFFF_FFFF, 64'd0, 1);
      check_output("lwu/const", data64, 64'h0000_0000_FFFF_FFFF);
      apply_stimulus("lw64", 1, 0, 0, 5'd6, 2'b01, 3'b010, 64'h0, 64'hFFFF_FFFF, 64'd0, 1);
      check_output("lw64/const", data64, 64'hFFFF_FFFF_FFFF_FFFF);
      apply_stimulus("ld", 1, 0, 0, 5'd6, 2'b01, 3'b011, 64'h0, 64'h0123_4567_89AB_CDEF, 64'd0, 1);
      apply_stimulus("ldmis", 1, 0, 0, 5'd6, 2'b01, 3'b011, 64'h4, 64'h0123_4567_89AB_CDEF, 64'd0, 1);

      // Five issued: one flushed, one misaligned, three retire.
      base32 = cnt32;
      base64 = cnt64;
      apply_stimulus("ret1", 1, 0, 0, 5'd11, 2'b00, 3'd0, 64'h10, 64'd0, 64'd0, 1);
      apply_stimulus("ret2", 1, 0, 1, 5'd12, 2'b00, 3'd0, 64'h20, 64'd0, 64'd0, 1);
      apply_stimulus("ret3", 1, 0, 0, 5'd13, 2'b01, 3'b010, 64'h2, 64'd0, 64'd0, 1);
      apply_stimulus("ret4", 1, 0, 0, 5'd14, 2'b00, 3'd0, 64'h40, 64'd0, 64'd0, 1);
      apply_stimulus("ret5", 1, 0, 0, 5'd15, 2'b01, 3'b000, 64'h3, 64'h1234, 64'd0, 1);
`ifdef WB_RETIRE_CNT_EN
      check_output("instret/x32 delta", cnt32 - base32, 64'd3);
      check_output("instret/x64 delta", cnt64 - base64, 64'd3);
`endif

      for (int n = 0; n < 300; n++) begin
         apply_stimulus("rand",
                        $urandom_range(0, 9) < 8,
                        $urandom_range(0, 19) < 3,
                        $urandom_range(0, 19) < 2,
                        5'($urandom_range(0, 31)),
                        2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7)),
                        {32'($urandom), 32'($urandom)},
                        {32'($urandom), 32'($urandom)},
                        {32'($urandom), 32'($urandom)},
                        $urandom_range(0, 9) < 9);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
